cont_rre_gen: RTL



---
 rtl/cont_rre_gen_if.sv | 24 ++
 rtl/cont_rre_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cont_rre_gen_if.sv
// Control and result bundle for the cont_rre_gen reciprocal frequency meter.
interface cont_rre_gen_if #(
    parameter int CNT_W = 32
);
    logic             en;
    logic             div_clk;
    logic             signal_x;
    logic [CNT_W-1:0] fcont_0;
    logic [CNT_W-1:0] fcont_x;
    logic             valid;
    logic             ovf;
    logic             timeout;
    logic             busy;

    modport master (
        output en, div_clk, signal_x,
        input  fcont_0, fcont_x, valid, ovf, timeout, busy
    );

    modport slave (
        input  en, div_clk, signal_x,
        output fcont_0, fcont_x, valid, ovf, timeout, busy
    );
endinterface

// File: rtl/cont_rre_gen.sv
// Equal-precision frequency meter: counts clk cycles and signal_x periods over a
// gate window whose start and stop are both aligned to rising edges of signal_x.
module cont_rre_gen #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int INT_GATE    = 0,
    parameter int GATE_LEN    = 1000000,
    parameter int TIMEOUT     = 1048576
) (
    input logic           clk,
    input logic           rst,
    cont_rre_gen_if.slave bus
);
    localparam int TMAX  = (TIMEOUT > GATE_LEN) ? TIMEOUT : GATE_LEN;
    localparam int TMR_W = $clog2(TMAX + 2);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_LEN - 1);

    typedef enum logic [2:0] {IDLE, ARMED, COUNT, CLOSING, DONE} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cont_0_q, cont_x_q;
    logic [CNT_W-1:0]       fcont_0_q, fcont_x_q;
    logic [TMR_W-1:0]       tmr_q;
    logic                   sat_q, valid_q, ovf_q, timeout_q, busy_q;

    logic                   sig_rise, gate, tmr_expired;
    logic [CNT_W-1:0]       cont_0_d, cont_x_d;
    logic                   sat_0_d, sat_x_d;
    logic [TMR_W-1:0]       tmr_d;

    assign sig_rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign tmr_expired = (tmr_q == TO_LAST);
    assign tmr_d       = tmr_q + TMR_W'(1);

    always_comb begin
        sat_0_d  = &cont_0_q;
        sat_x_d  = &cont_x_q;
        cont_0_d = sat_0_d ? cont_0_q : cont_0_q + CNT_W'(1);
        cont_x_d = sat_x_d ? cont_x_q : cont_x_q + CNT_W'(1);
    end

    // Internal gate drops on the cycle whose count (itself included) reaches GATE_LEN,
    // so an edge landing exactly there is the stop edge; tmr_q is used as cont_0 may saturate.
    always_comb begin
        if (INT_GATE == 0)
            gate = bus.div_clk;
        else if (state_q == COUNT)
            gate = (tmr_q < GATE_LAST);
        else
            gate = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            cont_0_q  <= '0;
            cont_x_q  <= '0;
            fcont_0_q <= '0;
            fcont_x_q <= '0;
            tmr_q     <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.signal_x};
            prev_q    <= sync_q[SYNC_STAGES-1];
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (!bus.en) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                cont_0_q <= '0;
                cont_x_q <= '0;
                tmr_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cont_0_q <= '0;
                        cont_x_q <= '0;
                        tmr_q    <= '0;
                        if (gate) begin
                            state_q <= ARMED;
                            busy_q  <= 1'b1;
                            sat_q   <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (sig_rise) begin
                            cont_0_q <= '0;
                            cont_x_q <= '0;
                            tmr_q    <= '0;
                            state_q  <= COUNT;
                        end else if (tmr_expired) begin
                            timeout_q <= 1'b1;
                            tmr_q     <= '0;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            tmr_q <= tmr_d;
                        end
                    end
                    COUNT: begin
                        cont_0_q <= cont_0_d;
                        if (sig_rise)
                            cont_x_q <= cont_x_d;
                        sat_q <= sat_q | sat_0_d | (sig_rise & sat_x_d);
                        if (!gate) begin
                            tmr_q   <= '0;
                            state_q <= sig_rise ? DONE : CLOSING;
                        end else begin
                            tmr_q <= tmr_d;
                        end
                    end
                    CLOSING: begin
                        cont_0_q <= cont_0_d;
                        sat_q    <= sat_q | sat_0_d | (sig_rise & sat_x_d);
                        if (sig_rise) begin
                            cont_x_q <= cont_x_d;
                            tmr_q    <= '0;
                            state_q  <= DONE;
                        end else if (tmr_expired) begin
                            timeout_q <= 1'b1;
                            tmr_q     <= '0;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            tmr_q <= tmr_d;
                        end
                    end
                    DONE: begin
                        fcont_0_q <= cont_0_q;
                        fcont_x_q <= cont_x_q;
                        ovf_q     <= sat_q;
                        valid_q   <= 1'b1;
                        tmr_q     <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.fcont_0 = fcont_0_q;
    assign bus.fcont_x = fcont_x_q;
    assign bus.valid   = valid_q;
    assign bus.ovf     = ovf_q;
    assign bus.timeout = timeout_q;
    assign bus.busy    = busy_q;
endmodule
